otter_iobus_timer: RTL

//  Memory-mapped IOBUS responder for the OTTER MCU: the device end of the MCU's IOBUS_ADDR/IOBUS_OUT/IOBUS_WR/IOBUS_IN

---
 rtl/otter_io_pkg.sv | 31 +++
 rtl/otter_sync_edge.sv | 32 +++
 rtl/otter_iobus_timer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/otter_io_pkg.sv
// Shared definitions for the OTTER IOBUS timer/switch responder: register map,
// status bit positions and the control register layout.
package otter_io_pkg;

    // Word offsets within the register window (IOBUS_ADDR[4:2])
    localparam logic [2:0] OFF_CTRL  = 3'd0;
    localparam logic [2:0] OFF_PRESC = 3'd1;
    localparam logic [2:0] OFF_CMP   = 3'd2;
    localparam logic [2:0] OFF_COUNT = 3'd3;
    localparam logic [2:0] OFF_STAT  = 3'd4;
    localparam logic [2:0] OFF_SW    = 3'd5;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_AUTO_BIT   = 1;
    localparam int CTRL_IE_TMR_BIT = 2;
    localparam int CTRL_IE_SW_BIT  = 3;

    localparam int STAT_TMR_BIT = 0;
    localparam int STAT_SW_BIT  = 1;

    localparam int PRESC_WIDTH = 16;

    // Packed so that en lands on bit 0, matching the bus view of CTRL
    typedef struct packed {
        logic ie_sw;
        logic ie_tmr;
        logic auto_rl;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/otter_sync_edge.sv
// Two-flop synchronizer for a bank of asynchronous inputs, plus a flag that is
// high whenever the synchronized value differs from the previous sample.
module otter_sync_edge #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic             change_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o   = sync_q;
    assign change_o = |(sync_q ^ prev_q);

endmodule

// File: rtl/otter_iobus_timer.sv
// OTTER IOBUS device: prescaled compare timer with auto-reload/one-shot and a
// synchronized switch port, with a level interrupt held until software clears it.
module otter_iobus_timer
    import otter_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
    parameter int          SW_WIDTH  = 16,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [31:0]         IOBUS_ADDR,
    input  logic [31:0]         IOBUS_OUT,
    input  logic                IOBUS_WR,
    output logic [31:0]         IOBUS_IN,
    input  logic [SW_WIDTH-1:0] SWITCHES,
    output logic                INTR
);

    logic [2:0]             off;
    logic                   hit;
    logic                   wr_hit;
    logic                   unused_addr;

    ctrl_t                  ctrl_q, ctrl_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [PRESC_WIDTH-1:0] pcnt_q, pcnt_d;
    logic [CNT_WIDTH-1:0]   cmp_q, cmp_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   tmr_flag_q, tmr_flag_d;
    logic                   sw_flag_q, sw_flag_d;

    logic                   tick;
    logic                   cnt_wr;
    logic                   tmr_set;
    logic [SW_WIDTH-1:0]    sw_sync;
    logic                   sw_change;

    assign off         = IOBUS_ADDR[4:2];
    assign hit         = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]) && (off <= OFF_SW);
    assign wr_hit      = IOBUS_WR && hit;
    assign cnt_wr      = wr_hit && (off == OFF_COUNT);
    assign unused_addr = ^IOBUS_ADDR[1:0];

    assign tick = ctrl_q.en && (pcnt_q == presc_q);

    otter_sync_edge #(
        .WIDTH(SW_WIDTH)
    ) u_sync (
        .clk_i   (CLK),
        .rst_ni  (RESET_N),
        .async_i (SWITCHES),
        .sync_o  (sw_sync),
        .change_o(sw_change)
    );

    always_comb begin
        ctrl_d     = ctrl_q;
        presc_d    = presc_q;
        pcnt_d     = pcnt_q;
        cmp_d      = cmp_q;
        count_d    = count_q;
        tmr_flag_d = tmr_flag_q;
        sw_flag_d  = sw_flag_q;
        tmr_set    = 1'b0;

        if (!ctrl_q.en || tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + 16'd1;
        end

        // A software COUNT load in the tick cycle suppresses the compare entirely
        if (tick && !cnt_wr) begin
            if (count_q == cmp_q) begin
                tmr_set = 1'b1;
                if (ctrl_q.auto_rl) begin
                    count_d = '0;
                end else begin
                    ctrl_d.en = 1'b0;
                end
            end else begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end

        if (wr_hit) begin
            case (off)
                OFF_CTRL:  ctrl_d = ctrl_t'(IOBUS_OUT[3:0]);
                OFF_PRESC: begin
                    presc_d = IOBUS_OUT[PRESC_WIDTH-1:0];
                    pcnt_d  = '0;
                end
                OFF_CMP:   cmp_d   = IOBUS_OUT[CNT_WIDTH-1:0];
                OFF_COUNT: count_d = IOBUS_OUT[CNT_WIDTH-1:0];
                OFF_STAT: begin
                    if (IOBUS_OUT[STAT_TMR_BIT]) tmr_flag_d = 1'b0;
                    if (IOBUS_OUT[STAT_SW_BIT])  sw_flag_d  = 1'b0;
                end
                default: ;
            endcase
        end

        // Hardware set events override a same-cycle write-one-to-clear
        if (tmr_set)   tmr_flag_d = 1'b1;
        if (sw_change) sw_flag_d  = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ctrl_q     <= '0;
            presc_q    <= '0;
            pcnt_q     <= '0;
            cmp_q      <= '0;
            count_q    <= '0;
            tmr_flag_q <= 1'b0;
            sw_flag_q  <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            presc_q    <= presc_d;
            pcnt_q     <= pcnt_d;
            cmp_q      <= cmp_d;
            count_q    <= count_d;
            tmr_flag_q <= tmr_flag_d;
            sw_flag_q  <= sw_flag_d;
        end
    end

    always_comb begin
        IOBUS_IN = '0;
        if (hit) begin
            case (off)
                OFF_CTRL:  IOBUS_IN[3:0]             = ctrl_q;
                OFF_PRESC: IOBUS_IN[PRESC_WIDTH-1:0] = presc_q;
                OFF_CMP:   IOBUS_IN[CNT_WIDTH-1:0]   = cmp_q;
                OFF_COUNT: IOBUS_IN[CNT_WIDTH-1:0]   = count_q;
                OFF_STAT: begin
                    IOBUS_IN[STAT_TMR_BIT] = tmr_flag_q;
                    IOBUS_IN[STAT_SW_BIT]  = sw_flag_q;
                end
                OFF_SW:    IOBUS_IN[SW_WIDTH-1:0]    = sw_sync;
                default:   IOBUS_IN = '0;
            endcase
        end
    end

    assign INTR = (tmr_flag_q & ctrl_q.ie_tmr) | (sw_flag_q & ctrl_q.ie_sw);

endmodule
